// File: rtl/semaforo_controlador.sv
// Two-approach traffic-light FSM driving the calle block's semaforo_a/semaforo_b codes.
// Phases are cycle-counted; latched requests may cut the opposing green after a minimum time.
package semaforo_pkg;
  typedef enum logic [2:0] {
    A_VERDE    = 3'd0,
    A_AMARILLO = 3'd1,
    ROJO_1     = 3'd2,
    B_VERDE    = 3'd3,
    B_AMARILLO = 3'd4,
    ROJO_2     = 3'd5
  } state_t;
endpackage

module semaforo_controlador
  import semaforo_pkg::*;
#(
  parameter int T_VERDE     = 8,
  parameter int T_AMARILLO  = 2,
  parameter int T_TODO_ROJO = 1,
  parameter int T_MIN_VERDE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic       solicitud_a,
  input  logic       solicitud_b,
  output logic [1:0] semaforo_a,
  output logic [1:0] semaforo_b,
  output logic [2:0] fase
);

  localparam logic [1:0] VERDE    = 2'b10;
  localparam logic [1:0] AMARILLO = 2'b01;
  localparam logic [1:0] ROJO     = 2'b00;

  state_t     state, state_nx;
  logic [7:0] cnt;
  logic [7:0] dur;
  logic       pend_a, pend_b;
  logic       ilegal, fin_tiempo, corte, salir;
  logic       entra_a, entra_b;

  // Light pair {a, b} shown while in state s.
  function automatic logic [3:0] luces(input state_t s);
    case (s)
      A_VERDE:    luces = {VERDE, ROJO};
      A_AMARILLO: luces = {AMARILLO, ROJO};
      B_VERDE:    luces = {ROJO, VERDE};
      B_AMARILLO: luces = {ROJO, AMARILLO};
      default:    luces = {ROJO, ROJO};
    endcase
  endfunction

  always_comb begin
    dur      = 8'(T_VERDE);
    state_nx = A_VERDE;
    ilegal   = 1'b0;
    case (state)
      A_VERDE:    begin dur = 8'(T_VERDE);     state_nx = A_AMARILLO; end
      A_AMARILLO: begin dur = 8'(T_AMARILLO);  state_nx = ROJO_1;     end
      ROJO_1:     begin dur = 8'(T_TODO_ROJO); state_nx = B_VERDE;    end
      B_VERDE:    begin dur = 8'(T_VERDE);     state_nx = B_AMARILLO; end
      B_AMARILLO: begin dur = 8'(T_AMARILLO);  state_nx = ROJO_2;     end
      ROJO_2:     begin dur = 8'(T_TODO_ROJO); state_nx = A_VERDE;    end
      default:    ilegal = 1'b1;
    endcase
  end

  // Only greens can be cut short; yellow and all-red always run their full time.
  always_comb begin
    fin_tiempo = (cnt == dur - 8'd1);
    corte      = 1'b0;
    if (cnt >= 8'(T_MIN_VERDE - 1)) begin
      if (state == A_VERDE) corte = pend_b | solicitud_b;
      if (state == B_VERDE) corte = pend_a | solicitud_a;
    end
    salir   = enb & ~ilegal & (fin_tiempo | corte);
    entra_a = ilegal | (salir & (state_nx == A_VERDE));
    entra_b = salir & (state_nx == B_VERDE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                    <= A_VERDE;
      cnt                      <= 8'd0;
      pend_a                   <= 1'b0;
      pend_b                   <= 1'b0;
      {semaforo_a, semaforo_b} <= luces(A_VERDE);
    end else begin
      if (ilegal) begin
        state                    <= A_VERDE;
        cnt                      <= 8'd0;
        {semaforo_a, semaforo_b} <= luces(A_VERDE);
      end else if (salir) begin
        state                    <= state_nx;
        cnt                      <= 8'd0;
        {semaforo_a, semaforo_b} <= luces(state_nx);
      end else if (enb) begin
        cnt <= cnt + 8'd1;
      end
      // Latching ignores enb; entry into the green wins over a same-cycle request.
      if (entra_a)                               pend_a <= 1'b0;
      else if (solicitud_a && state != A_VERDE)  pend_a <= 1'b1;
      if (entra_b)                               pend_b <= 1'b0;
      else if (solicitud_b && state != B_VERDE)  pend_b <= 1'b1;
    end
  end

  assign fase = state;

endmodule

// File: tb/tb_semaforo_controlador.sv
// Scoreboard bench: stimulus pushes expected lights from a phase-table model, monitor pops and compares.
module tb_semaforo_controlador;
  localparam int TV = 8, TA = 2, TR = 1, TMIN = 3;

  logic       clk = 1'b0;
  logic       reset, enb, solicitud_a, solicitud_b;
  logic [1:0] semaforo_a, semaforo_b;
  logic [2:0] fase;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  // Reference model: current phase index, enabled cycles spent in it, pending requests.
  int ph = 0, el = 0;
  bit pa = 0, pb = 0;
  int dur_t[6] = '{TV, TA, TR, TV, TA, TR};
  logic [3:0] luz_t[6] = '{4'b1000, 4'b0100, 4'b0000, 4'b0010, 4'b0001, 4'b0000};

  semaforo_controlador #(.T_VERDE(TV), .T_AMARILLO(TA), .T_TODO_ROJO(TR), .T_MIN_VERDE(TMIN)) dut (
    .clk(clk), .reset(reset), .enb(enb),
    .solicitud_a(solicitud_a), .solicitud_b(solicitud_b),
    .semaforo_a(semaforo_a), .semaforo_b(semaforo_b), .fase(fase)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit r, input bit e, input bit ra, input bit rb, input bit ill);
    int  nph;
    bit  cut;
    if (!r) begin
      ph = 0; el = 0; pa = 0; pb = 0;
    end else if (ill) begin
      ph = 0; el = 0; pa = 0;
      if (rb) pb = 1;
    end else begin
      nph = ph;
      if (e) begin
        cut = (el >= TMIN - 1) && ((ph == 0 && (pb || rb)) || (ph == 3 && (pa || ra)));
        if (el == dur_t[ph] - 1 || cut) nph = (ph + 1) % 6;
      end
      if (ra && ph != 0) pa = 1;
      if (rb && ph != 3) pb = 1;
      if (nph != ph) begin
        if (nph == 0) pa = 0;
        if (nph == 3) pb = 0;
        el = 0;
      end else if (e) begin
        el++;
      end
      ph = nph;
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit ra, input bit rb, input bit ill);
    reset = r; enb = e; solicitud_a = ra; solicitud_b = rb;
    if (ill) force dut.state = semaforo_pkg::state_t'(3'd7);
    model_step(r, e, ra, rb, ill);
    exp_q.push_back({luz_t[ph], 3'(ph)});
    if (ill) begin
      #1 release dut.state;
    end
    @(negedge clk);
  endtask

  task automatic wait_for(input int wph, input int wel);
    int n = 0;
    while (!(ph == wph && el == wel) && n < 100) begin
      cyc(1, 1, 0, 0, 0);
      n++;
    end
    if (!(ph == wph && el == wel)) begin
      checks++; errors++;
      $display("FAIL wait_for phase=%0d cnt=%0d not reached (at phase=%0d cnt=%0d)", wph, wel, ph, el);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a light pair; compare against the queued expectation.
  always @(posedge clk) begin
    logic [6:0] x;
    #1;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      checks++;
      if ({semaforo_a, semaforo_b, fase} !== x) begin
        errors++;
        $display("FAIL lights t=%0t got a=%b b=%b fase=%0d exp a=%b b=%b fase=%0d",
                 $time, semaforo_a, semaforo_b, fase, x[6:5], x[4:3], x[2:0]);
      end
      checks++;
      if (semaforo_a != 2'b00 && semaforo_b != 2'b00) begin
        errors++;
        $display("FAIL safety t=%0t got a=%b b=%b exp one side red", $time, semaforo_a, semaforo_b);
      end
    end
  end

  initial begin
    // Reset state, even with enb low.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    // Free run, several full periods.
    run(50);
    // Freeze at A green counter 4.
    wait_for(0, 4);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
    run(10);
    // Early request at counter 0.
    wait_for(0, 0);
    cyc(1, 1, 0, 1, 0);
    run(25);
    // Late request at counter 6, then at counter 7.
    wait_for(0, 6);
    cyc(1, 1, 0, 1, 0);
    run(5);
    wait_for(0, 7);
    cyc(1, 1, 0, 1, 0);
    run(5);
    // Request latched during frozen A yellow, then reset mid B yellow.
    wait_for(1, 0);
    cyc(1, 0, 1, 0, 0);
    wait_for(4, 0);
    cyc(0, 1, 0, 0, 0);
    run(12);
    // Request for the already-green approach is ignored.
    wait_for(0, 0);
    while (ph == 0) cyc(1, 1, 1, 0, 0);
    run(15);
    // Illegal state recovery.
    cyc(1, 1, 0, 0, 1);
    run(5);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 8),
          ($urandom_range(0, 14) == 0), ($urandom_range(0, 14) == 0),
          ($urandom_range(0, 599) == 0));
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/semaforo_controlador.md
Name: semaforo_controlador

Overview:
- Traffic-light controller FSM that generates the 2-bit semaforo_a / semaforo_b light codes consumed by the street (calle) block. It is the driving end of that interface.
- Sequences the two approaches through green, yellow and all-red phases using cycle counters.
- Honours latched pedestrian/side requests that can shorten the opposing green after a minimum green time.
- Sits between the clock/enable source and the calle block; replaces hand-driven stimulus in system-level sims.

Parameters:
- T_VERDE, 8: green duration in enabled cycles (1..255).
- T_AMARILLO, 2: yellow duration in enabled cycles (1..255).
- T_TODO_ROJO, 1: all-red clearance duration in enabled cycles (1..255).
- T_MIN_VERDE, 3: minimum green before a request may cut it short (1..T_VERDE).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- enb  input  1  enable; 0 freezes state, counter and outputs.
- solicitud_a  input  1  request for approach A green (pedestrian/sensor on A side).
- solicitud_b  input  1  request for approach B green.
- semaforo_a  output  2  light code A: 2'b10 green, 2'b01 yellow, 2'b00 red; 2'b11 never driven.
- semaforo_b  output  2  light code B, same encoding.
- fase  output  3  current FSM state code (debug/observability).

Behaviour:
- All outputs are registered and update on the same edge as the state change (Moore, no combinational path from inputs to outputs).
- States and codes, with outputs (a, b):
  - A_VERDE=0: 10, 00
  - A_AMARILLO=1: 01, 00
  - ROJO_1=2: 00, 00
  - B_VERDE=3: 00, 10
  - B_AMARILLO=4: 00, 01
  - ROJO_2=5: 00, 00
- Codes 6–7 are illegal and recover to A_VERDE on the next edge.
- Reset (reset==0 at posedge, regardless of enb):
  - State A_VERDE, counter 0, pend_a=0, pend_b=0.
  - semaforo_a=10, semaforo_b=00, fase=0.
  - Reset mid-phase aborts the phase immediately.
- Counter: 8-bit, counts enabled cycles spent in the current state, starting at 0 on entry.
  - Natural exit when counter==T_x-1 and enb=1; that edge moves to the next state and clears the counter.
  - Each state therefore lasts exactly T_x enabled cycles.
- Sequence: A_VERDE -> A_AMARILLO -> ROJO_1 -> B_VERDE -> B_AMARILLO -> ROJO_2 -> A_VERDE. Period with defaults: 22 cycles.
- enb=0: state, counter and outputs hold. Request latching still occurs, so requests are never lost while frozen.
- Request latching:
  - pend_b is set on any edge with solicitud_b=1 while the state is not B_VERDE.
  - pend_b is cleared on the edge that enters B_VERDE.
  - pend_a is the symmetric case for A_VERDE.
  - A request for the approach that is already green is ignored and not latched.
- Early exit from A_VERDE: when (pend_b | solicitud_b) and counter>=T_MIN_VERDE-1 and enb=1, exit to A_AMARILLO on that edge. B_VERDE is symmetric with pend_a / solicitud_a.
- Early exit never shortens yellow or all-red.
- Simultaneous early and natural exit conditions produce a single transition.
- A request arriving in the same cycle as entry into that approach's green is dropped, because the approach is now green.
- Safety invariant: never both approaches non-red at once; yellow is always followed by an all-red state.

Test Plan:
- Free run: release reset with enb=1 and no requests -> a=10 for 8 cycles, 01 for 2, (00,00) for 1, b=10 for 8, b=01 for 2, (00,00) for 1; repeats with period 22; fase steps 0..5.
- Freeze: drop enb=0 for 5 cycles at A_VERDE counter 4 -> outputs and fase hold; A green totals 13 wall cycles (8 enabled).
- Early request: pulse solicitud_b for 1 cycle at A_VERDE counter 0 -> semaforo_a goes 01 after 3 cycles of green; pend_b clears on entry to B_VERDE (fase 3).
- Late request: solicitud_b=1 at A_VERDE counter 6 -> transition on that edge, green lasted 7 cycles. The same request held at counter 7 gives the normal 8-cycle green with one transition only.
- Reset mid-operation: reset=0 for 1 cycle during B_AMARILLO with pend_a set -> next cycle a=10, b=00, fase=0, pend_a=0, and A green lasts a full 8 cycles.
- Ignored request and illegal state: solicitud_a held during A_VERDE -> no effect on B_VERDE length (8 cycles). Forcing fase to 7 -> next edge fase=0, a=10, b=00.
